// File: rtl/ccl_scan_sequencer_pkg.sv
// Shared constants for the CCL scan sequencer: global word size, coordinate width
// and the legacy-compatible FSM state encoding.
package ccl_scan_sequencer_pkg;

    localparam int CCL_WORD_SIZE = 8;
    localparam int CCL_MAX_DIM   = 4096;
    localparam int CCL_COORD_W   = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLEAR     = 3'd1;
    localparam logic [2:0] ST_ROW_START = 3'd2;
    localparam logic [2:0] ST_SCAN      = 3'd3;
    localparam logic [2:0] ST_FLUSH     = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/ccl_scan_sequencer_label_line_buffer.sv
// One-row label store: synchronous write of the current label, asynchronous read
// of the label above-right. Reads past the row end return zero.
module label_line_buffer
    import ccl_scan_sequencer_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int WORD_SIZE = CCL_WORD_SIZE,
    parameter int IW        = $clog2(WIDTH),
    parameter int AW        = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [IW-1:0]        i_wr_addr,
    input  logic [WORD_SIZE-1:0] i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    output logic [WORD_SIZE-1:0] o_rd_data
);

    logic [WORD_SIZE-1:0] r_mem [WIDTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = (i_rd_addr < AW'(WIDTH)) ? r_mem[i_rd_addr[IW-1:0]] : '0;

endmodule

// File: rtl/ccl_scan_sequencer.sv
// Raster-scan sequencer feeding the connected-components labeler one pixel per accepted
// beat, building its A/B/C/D window and flushing its merge stacks at frame end.
module ccl_scan_sequencer
    import ccl_scan_sequencer_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int WORD_SIZE    = CCL_WORD_SIZE,
    parameter int FLUSH_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   s_valid,
    input  logic [WORD_SIZE-1:0]   s_data,
    output logic                   s_ready,
    output logic                   ccl_reset_n,
    output logic                   ccl_en,
    output logic [WORD_SIZE-1:0]   ccl_A,
    output logic [WORD_SIZE-1:0]   ccl_B,
    output logic [WORD_SIZE-1:0]   ccl_C,
    output logic [WORD_SIZE-1:0]   ccl_D,
    output logic [WORD_SIZE-1:0]   ccl_data,
    output logic [CCL_COORD_W-1:0] ccl_x,
    output logic [CCL_COORD_W-1:0] ccl_y,
    input  logic [WORD_SIZE-1:0]   ccl_q,
    output logic                   m_valid,
    output logic [WORD_SIZE-1:0]   m_label,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int XW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT) + 1;
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;

    logic [2:0]           r_state;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [FW-1:0]        r_flush_cnt;
    logic [WORD_SIZE-1:0] r_a;
    logic [WORD_SIZE-1:0] r_b;
    logic [WORD_SIZE-1:0] r_d;
    logic                 r_m_valid;
    logic [WORD_SIZE-1:0] r_m_label;
    logic                 r_m_last;

    logic                 w_scan;
    logic                 w_flush;
    logic                 w_out_ready;
    logic                 w_accept;
    logic                 w_row_end;
    logic                 w_last_row;
    logic                 w_x_zero;
    logic                 w_y_zero;
    logic [XW-1:0]        w_rd_addr;
    logic [WORD_SIZE-1:0] w_rd_data;

    assign w_scan      = (r_state == ST_SCAN);
    assign w_flush     = (r_state == ST_FLUSH);
    assign w_out_ready = !r_m_valid || m_ready;
    assign w_accept    = w_scan && s_valid && w_out_ready;
    assign w_row_end   = (r_x == XW'(WIDTH - 1));
    assign w_last_row  = (r_y == YW'(HEIGHT - 1));
    assign w_x_zero    = (r_x == '0);
    assign w_y_zero    = (r_y == '0);
    // Row start fetches the label above column 0; scanning fetches the one above-right.
    assign w_rd_addr   = w_scan ? (r_x + XW'(1)) : '0;

    label_line_buffer #(
        .WIDTH     (WIDTH),
        .WORD_SIZE (WORD_SIZE)
    ) u_line_buffer (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_x[IW-1:0]),
        .i_wr_data (ccl_q),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign s_ready     = w_scan && w_out_ready;
    assign ccl_en      = w_accept || w_flush;
    assign ccl_reset_n = (r_state != ST_CLEAR);
    assign ccl_A       = (w_scan && !w_x_zero && !w_y_zero) ? r_a : '0;
    assign ccl_B       = (w_scan && !w_y_zero) ? r_b : '0;
    assign ccl_C       = (w_scan && !w_row_end && !w_y_zero) ? w_rd_data : '0;
    assign ccl_D       = (w_scan && !w_x_zero) ? r_d : '0;
    assign ccl_data    = w_scan ? s_data : '0;
    // Flush reports y = HEIGHT so the labeler's row parity flips and pops the last row's stacks.
    assign ccl_x       = w_scan  ? CCL_COORD_W'(r_x) :
                         w_flush ? CCL_COORD_W'(r_flush_cnt) : '0;
    assign ccl_y       = w_scan  ? CCL_COORD_W'(r_y) :
                         w_flush ? CCL_COORD_W'(HEIGHT) : '0;

    assign m_valid     = r_m_valid;
    assign m_label     = r_m_label;
    assign m_last      = r_m_last;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_flush_cnt <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_m_valid   <= 1'b0;
            r_m_label   <= '0;
            r_m_last    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_label <= ccl_q;
                r_m_last  <= w_row_end && w_last_row;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_x     <= '0;
                    r_y     <= '0;
                    r_state <= ST_ROW_START;
                end
                ST_ROW_START: begin
                    r_b     <= w_y_zero ? '0 : w_rd_data;
                    r_a     <= '0;
                    r_d     <= '0;
                    r_x     <= '0;
                    r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_accept) begin
                        r_d <= ccl_q;
                        r_a <= r_b;
                        r_b <= ccl_C;
                        r_x <= r_x + XW'(1);
                        if (w_row_end) begin
                            if (w_last_row) begin
                                r_flush_cnt <= '0;
                                r_state     <= ST_FLUSH;
                            end else begin
                                r_y     <= r_y + YW'(1);
                                r_state <= ST_ROW_START;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccl_scan_sequencer.sv
// Self-checking bench for ccl_scan_sequencer on a 4x3 frame, with a behavioural
// min-neighbour labeler standing in for the real one and a scoreboard on the label stream.
module tb_ccl_scan_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FL = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        ccl_reset_n;
    logic        ccl_en;
    logic [7:0]  ccl_A, ccl_B, ccl_C, ccl_D, ccl_data, ccl_q;
    logic [31:0] ccl_x, ccl_y;
    logic        m_valid;
    logic [7:0]  m_label;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int enCount = 0;
    int clrCount = 0;
    int doneCount = 0;
    int flushBeats = 0;
    bit throttle = 1'b0;
    logic [8:0] expQ [$];
    logic [7:0] img    [H][W];
    logic [7:0] expLab [H][W];
    logic [7:0] winA   [H][W];
    logic [7:0] winB   [H][W];
    logic [7:0] winC   [H][W];
    logic [7:0] winD   [H][W];
    logic [7:0] nextLabel = 8'd1;

    always #5 clk = ~clk;

    ccl_scan_sequencer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .WORD_SIZE    (8),
        .FLUSH_CYCLES (FL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .ccl_reset_n (ccl_reset_n),
        .ccl_en      (ccl_en),
        .ccl_A       (ccl_A),
        .ccl_B       (ccl_B),
        .ccl_C       (ccl_C),
        .ccl_D       (ccl_D),
        .ccl_data    (ccl_data),
        .ccl_x       (ccl_x),
        .ccl_y       (ccl_y),
        .ccl_q       (ccl_q),
        .m_valid     (m_valid),
        .m_label     (m_label),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done)
    );

    // Labeler stand-in: background -> 0, else smallest nonzero neighbour, else a fresh label.
    function automatic logic [7:0] labelOf(input logic [7:0] data, a, b, c, d, nxt);
        logic [7:0] m;
        m = 8'd0;
        if (data == 8'd0) return 8'd0;
        if (a != 8'd0 && (m == 8'd0 || a < m)) m = a;
        if (b != 8'd0 && (m == 8'd0 || b < m)) m = b;
        if (c != 8'd0 && (m == 8'd0 || c < m)) m = c;
        if (d != 8'd0 && (m == 8'd0 || d < m)) m = d;
        return (m == 8'd0) ? nxt : m;
    endfunction

    assign ccl_q = labelOf(ccl_data, ccl_A, ccl_B, ccl_C, ccl_D, nextLabel);

    always @(posedge clk) begin
        if (!ccl_reset_n) nextLabel <= 8'd1;
        else if (ccl_en && ccl_data != 8'd0 && ccl_A == 8'd0 && ccl_B == 8'd0 &&
                 ccl_C == 8'd0 && ccl_D == 8'd0) nextLabel <= nextLabel + 8'd1;
    end

    task automatic computeExpected();
        logic [7:0] nxt, a, b, c, d;
        nxt = 8'd1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                a = (x > 0 && y > 0)     ? expLab[y-1][x-1] : 8'd0;
                b = (y > 0)              ? expLab[y-1][x]   : 8'd0;
                c = (x < W - 1 && y > 0) ? expLab[y-1][x+1] : 8'd0;
                d = (x > 0)              ? expLab[y][x-1]   : 8'd0;
                expLab[y][x] = labelOf(img[y][x], a, b, c, d, nxt);
                if (img[y][x] != 8'd0 && a == 8'd0 && b == 8'd0 && c == 8'd0 && d == 8'd0)
                    nxt = nxt + 8'd1;
            end
        end
    endtask

    task automatic clearImage();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 8'd0;
    endtask

    task automatic abortRun(input string what);
        errors++;
        $display("[TB] FAIL %s: bound expired, got no response, required a response", what);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] aborted");
    endtask

    task automatic monitorLoop();
        logic       prevStall;
        logic [7:0] prevLabel;
        logic [8:0] exp;
        prevStall = 1'b0;
        prevLabel = 8'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prevStall = 1'b0;
                continue;
            end
            if (ccl_en) enCount++;
            if (!ccl_reset_n) clrCount++;
            if (done) doneCount++;
            if (ccl_en && busy && ccl_y == 32'(H)) flushBeats++;
            if (prevStall) begin
                checks++;
                if (m_valid !== 1'b1 || m_label !== prevLabel) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%0b label=%0d, required valid=1 label=%0d",
                             m_valid, m_label, prevLabel);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got label=%0d, required no output", m_label);
                end else begin
                    exp = expQ.pop_front();
                    if ({m_last, m_label} !== exp) begin
                        errors++;
                        $display("[TB] FAIL label_stream: got last=%0b label=%0d, required last=%0b label=%0d",
                                 m_last, m_label, exp[8], exp[7:0]);
                    end
                end
            end
            prevStall = m_valid && !m_ready;
            prevLabel = m_label;
        end
    endtask

    task automatic throttleLoop();
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic watchdog();
        #200000;
        abortRun("watchdog");
    endtask

    task automatic applyPixel(input int px, input int py);
        int t;
        if (throttle) begin
            for (int i = 0; i < 3 && $urandom_range(0, 1) == 1; i++) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = img[py][px];
        t = 0;
        @(negedge clk);
        while (!s_ready) begin
            t++;
            if (t > 200) abortRun("accept_timeout");
            @(negedge clk);
        end
        checks++;
        if (ccl_x !== 32'(px) || ccl_y !== 32'(py)) begin
            errors++;
            $display("[TB] FAIL coord: got (%0d,%0d), required (%0d,%0d)", ccl_x, ccl_y, px, py);
        end
        winA[py][px] = ccl_A;
        winB[py][px] = ccl_B;
        winC[py][px] = ccl_C;
        winD[py][px] = ccl_D;
        expQ.push_back({(px == W - 1 && py == H - 1), expLab[py][px]});
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'd0;
    endtask

    task automatic runFrame(input bit thr, input int stopAfter);
        int e0, d0, c0, f0, n, t;
        computeExpected();
        e0 = enCount; d0 = doneCount; c0 = clrCount; f0 = flushBeats;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        throttle = thr;
        n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (stopAfter >= 0 && n >= stopAfter) begin
                    throttle = 1'b0;
                    return;
                end
                applyPixel(x, y);
                n++;
            end
        end
        throttle = 1'b0;
        t = 0;
        while (doneCount == d0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (doneCount - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL done_pulses: got %0d, required 1", doneCount - d0);
        end
        checks++;
        if (enCount - e0 !== W * H + FL) begin
            errors++;
            $display("[TB] FAIL en_count: got %0d, required %0d", enCount - e0, W * H + FL);
        end
        checks++;
        if (clrCount - c0 !== 1) begin
            errors++;
            $display("[TB] FAIL clear_cycles: got %0d, required 1", clrCount - c0);
        end
        checks++;
        if (flushBeats - f0 !== FL) begin
            errors++;
            $display("[TB] FAIL flush_beats: got %0d, required %0d", flushBeats - f0, FL);
        end
        checks++;
        if (expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL labels_drained: got %0d pending, required 0", expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, ccl_en, ccl_reset_n, m_valid, m_last, busy, done} !== 7'b0010000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, required 0010000",
                     {s_ready, ccl_en, ccl_reset_n, m_valid, m_last, busy, done});
        end
        checks++;
        if (m_label !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_label: got %0d, required 0", m_label);
        end
        checks++;
        if (ccl_x !== 32'd0 || ccl_y !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_coord: got (%0d,%0d), required (0,0)", ccl_x, ccl_y);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_zero();
        clearImage();
        runFrame(1'b0, -1);
    endtask

    task automatic test_single_pixel();
        clearImage();
        img[1][1] = 8'hA5;
        runFrame(1'b0, -1);
        checks++;
        if ({winA[1][1], winB[1][1], winC[1][1], winD[1][1]} !== 32'd0) begin
            errors++;
            $display("[TB] FAIL single_window: got A=%0d B=%0d C=%0d D=%0d, required all 0",
                     winA[1][1], winB[1][1], winC[1][1], winD[1][1]);
        end
    endtask

    task automatic test_vertical_bar();
        clearImage();
        for (int y = 0; y < H; y++) img[y][2] = 8'd1;
        runFrame(1'b0, -1);
        checks++;
        if (winB[1][2] !== 8'd1 || winB[2][2] !== 8'd1) begin
            errors++;
            $display("[TB] FAIL bar_above: got B=%0d,%0d, required 1,1", winB[1][2], winB[2][2]);
        end
        checks++;
        if (nextLabel !== 8'd2) begin
            errors++;
            $display("[TB] FAIL bar_alloc: got next label %0d, required 2", nextLabel);
        end
    endtask

    task automatic loadUShape();
        clearImage();
        img[0][0] = 8'd1;
        img[0][2] = 8'hFF;
        img[1][0] = 8'd1;
        img[1][1] = 8'd7;
        img[1][2] = 8'd1;
    endtask

    task automatic test_u_merge();
        loadUShape();
        runFrame(1'b0, -1);
        checks++;
        if (winA[1][1] !== 8'd1 || winC[1][1] !== 8'd2 || winD[1][1] !== 8'd1) begin
            errors++;
            $display("[TB] FAIL merge_window: got A=%0d C=%0d D=%0d, required 1 2 1",
                     winA[1][1], winC[1][1], winD[1][1]);
        end
    endtask

    task automatic test_throttled();
        loadUShape();
        img[2][3] = 8'd3;
        runFrame(1'b1, -1);
    endtask

    task automatic test_mid_reset();
        loadUShape();
        runFrame(1'b0, W + 2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expQ.delete();
        checks++;
        if ({busy, m_valid, s_ready, ccl_reset_n} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mid_reset_state: got %b, required 0001",
                     {busy, m_valid, s_ready, ccl_reset_n});
        end
        runFrame(1'b0, -1);
    endtask

    initial begin
        fork
            monitorLoop();
            throttleLoop();
            watchdog();
        join_none
        $display("[TB] starting");
        test_reset();
        test_all_zero();
        test_single_pixel();
        test_vertical_bar();
        test_u_merge();
        test_throttled();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
